// File: rtl/loadstore_unit_pkg.sv
// Shared definitions for the load/store unit: FUNC3 encodings, FSM states
// and the legality check for a given direction/func3 pair.
package loadstore_unit_pkg;

  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;
  localparam logic [2:0] FUNC3_SB  = 3'b000;
  localparam logic [2:0] FUNC3_SH  = 3'b001;
  localparam logic [2:0] FUNC3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE     = 2'd0,
    LSU_REQUEST  = 2'd1,
    LSU_WAIT_ACK = 2'd2,
    LSU_OUTPUT   = 2'd3
  } lsu_state_e;

  function automatic logic func3_legal(input logic we, input logic [2:0] f3);
    if (we)
      return f3 inside {FUNC3_SB, FUNC3_SH, FUNC3_SW};
    else
      return f3 inside {FUNC3_LB, FUNC3_LH, FUNC3_LW, FUNC3_LBU, FUNC3_LHU};
  endfunction

endpackage

// File: rtl/loadstore_unit_lane_align.sv
// Combinational lane handling: byte-select and store-data replication for the
// request side, byte/halfword extraction and extension for the load side.
module lsu_lane_align
  import loadstore_unit_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_func3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic        o_fault,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_sel   = 4'b0000;
    o_wdata = i_wdata;
    o_fault = !func3_legal(i_we, i_func3);
    // func3[1:0] encodes the access size for both loads and stores
    case (i_func3[1:0])
      2'b00: begin
        o_sel   = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_sel   = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_fault = o_fault | i_addr_lo[0];
      end
      2'b10: begin
        o_sel   = 4'hF;
        o_fault = o_fault | (i_addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

  assign w_byte = i_rdata[{i_ld_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_ld_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    case (i_ld_func3)
      FUNC3_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
      FUNC3_LBU: o_rdata = {24'h000000, w_byte};
      FUNC3_LH:  o_rdata = {{16{w_half[15]}}, w_half};
      FUNC3_LHU: o_rdata = {16'h0000, w_half};
      default:   o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/loadstore_unit.sv
// Memory-access stage: accepts one instruction at a time, runs a single
// Wishbone pipelined transfer for loads/stores and presents writeback data.
module loadstore_unit
  import loadstore_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic        mem_enable_i,
  input  logic        mem_we_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] result_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  output logic        output_valid_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic        misaligned_o,
  output logic        bus_error_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  lsu_state_e    r_state;
  logic [CW-1:0] r_count;
  logic [2:0]    r_ld_func3;
  logic [1:0]    r_ld_addr_lo;
  logic          r_pend_write;
  logic          r_output_valid;
  logic          r_reg_write;
  logic [4:0]    r_reg_addr;
  logic [31:0]   r_reg_data;
  logic          r_misaligned;
  logic          r_bus_error;
  logic [31:0]   r_wb_adr;
  logic [31:0]   r_wb_dat;
  logic          r_wb_we;
  logic [3:0]    r_wb_sel;
  logic          r_wb_stb;
  logic          r_wb_cyc;

  logic [3:0]    w_sel;
  logic [31:0]   w_wdata;
  logic          w_fault;
  logic [31:0]   w_ld_data;
  logic          w_timeout;
  logic          w_ack_taken;

  lsu_lane_align u_lane_align (
    .i_we         (mem_we_i),
    .i_func3      (func3_i),
    .i_addr_lo    (addr_i[1:0]),
    .i_wdata      (wdata_i),
    .i_ld_func3   (r_ld_func3),
    .i_ld_addr_lo (r_ld_addr_lo),
    .i_rdata      (wb_dat_i),
    .o_sel        (w_sel),
    .o_wdata      (w_wdata),
    .o_fault      (w_fault),
    .o_rdata      (w_ld_data)
  );

  assign w_timeout   = (ACK_TIMEOUT != 0) && (r_count == CW'(ACK_TIMEOUT - 1));
  // An ack only counts once the request has left the stalled REQUEST phase
  assign w_ack_taken = wb_ack_i && ((r_state == LSU_WAIT_ACK) || !wb_stall_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= LSU_IDLE;
      r_count        <= '0;
      r_ld_func3     <= 3'b000;
      r_ld_addr_lo   <= 2'b00;
      r_pend_write   <= 1'b0;
      r_output_valid <= 1'b0;
      r_reg_write    <= 1'b0;
      r_reg_addr     <= 5'd0;
      r_reg_data     <= 32'd0;
      r_misaligned   <= 1'b0;
      r_bus_error    <= 1'b0;
      r_wb_adr       <= 32'd0;
      r_wb_dat       <= 32'd0;
      r_wb_we        <= 1'b0;
      r_wb_sel       <= 4'b0000;
      r_wb_stb       <= 1'b0;
      r_wb_cyc       <= 1'b0;
    end else begin
      r_output_valid <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (input_valid_i) begin
            r_reg_addr   <= reg_addr_i;
            r_ld_func3   <= func3_i;
            r_ld_addr_lo <= addr_i[1:0];
            r_count      <= '0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            if (!mem_enable_i) begin
              r_output_valid <= 1'b1;
              r_reg_write    <= reg_write_i;
              r_reg_data     <= result_i;
              r_state        <= LSU_OUTPUT;
            end else if (w_fault) begin
              r_output_valid <= 1'b1;
              r_reg_write    <= 1'b0;
              r_reg_data     <= 32'd0;
              r_misaligned   <= 1'b1;
              r_state        <= LSU_OUTPUT;
            end else begin
              r_wb_cyc     <= 1'b1;
              r_wb_stb     <= 1'b1;
              r_wb_adr     <= {addr_i[31:2], 2'b00};
              r_wb_dat     <= w_wdata;
              r_wb_sel     <= w_sel;
              r_wb_we      <= mem_we_i;
              r_pend_write <= reg_write_i & ~mem_we_i;
              r_state      <= LSU_REQUEST;
            end
          end
        end
        LSU_REQUEST, LSU_WAIT_ACK: begin
          if (w_ack_taken) begin
            r_wb_cyc       <= 1'b0;
            r_wb_stb       <= 1'b0;
            r_output_valid <= 1'b1;
            r_reg_write    <= r_pend_write;
            r_reg_data     <= r_wb_we ? 32'd0 : w_ld_data;
            r_state        <= LSU_OUTPUT;
          end else if (w_timeout) begin
            r_wb_cyc       <= 1'b0;
            r_wb_stb       <= 1'b0;
            r_output_valid <= 1'b1;
            r_reg_write    <= 1'b0;
            r_reg_data     <= 32'd0;
            r_bus_error    <= 1'b1;
            r_state        <= LSU_OUTPUT;
          end else begin
            r_count <= r_count + 1'b1;
            if ((r_state == LSU_REQUEST) && !wb_stall_i) begin
              r_wb_stb <= 1'b0;
              r_state  <= LSU_WAIT_ACK;
            end
          end
        end
        LSU_OUTPUT: r_state <= LSU_IDLE;
        default:    r_state <= LSU_IDLE;
      endcase
    end
  end

  assign input_ready_o  = (r_state == LSU_IDLE);
  assign output_valid_o = r_output_valid;
  assign reg_write_o    = r_reg_write;
  assign reg_addr_o     = r_reg_addr;
  assign reg_data_o     = r_reg_data;
  assign misaligned_o   = r_misaligned;
  assign bus_error_o    = r_bus_error;
  assign wb_adr_o       = r_wb_adr;
  assign wb_dat_o       = r_wb_dat;
  assign wb_we_o        = r_wb_we;
  assign wb_sel_o       = r_wb_sel;
  assign wb_stb_o       = r_wb_stb;
  assign wb_cyc_o       = r_wb_cyc;

endmodule

// File: tb/tb_loadstore_unit.sv
// Directed bench for loadstore_unit: writeback results go through a scoreboard,
// bus-side behaviour is checked inline at each step.
module tb_loadstore_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid_a, valid_b;
  logic        mem_en, mem_we, rw;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, result, wb_rdata;
  logic [4:0]  ra;
  logic        stall, ack;

  logic        a_ready, a_valid, a_rw, a_mis, a_berr, a_we, a_stb, a_cyc;
  logic [4:0]  a_ra;
  logic [31:0] a_data, a_adr, a_dat;
  logic [3:0]  a_sel;
  logic        b_ready, b_valid, b_rw, b_mis, b_berr, b_we, b_stb, b_cyc;
  logic [4:0]  b_ra;
  logic [31:0] b_data, b_adr, b_dat;
  logic [3:0]  b_sel;

  loadstore_unit #(.ACK_TIMEOUT(255)) dut_a (
    .clk_i(clk), .rst_i(rst), .input_valid_i(valid_a), .input_ready_o(a_ready),
    .mem_enable_i(mem_en), .mem_we_i(mem_we), .func3_i(f3), .addr_i(addr),
    .wdata_i(wdata), .result_i(result), .reg_write_i(rw), .reg_addr_i(ra),
    .output_valid_o(a_valid), .reg_write_o(a_rw), .reg_addr_o(a_ra), .reg_data_o(a_data),
    .misaligned_o(a_mis), .bus_error_o(a_berr), .wb_adr_o(a_adr), .wb_dat_o(a_dat),
    .wb_dat_i(wb_rdata), .wb_we_o(a_we), .wb_sel_o(a_sel), .wb_stb_o(a_stb),
    .wb_cyc_o(a_cyc), .wb_stall_i(stall), .wb_ack_i(ack)
  );

  loadstore_unit #(.ACK_TIMEOUT(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .input_valid_i(valid_b), .input_ready_o(b_ready),
    .mem_enable_i(mem_en), .mem_we_i(mem_we), .func3_i(f3), .addr_i(addr),
    .wdata_i(wdata), .result_i(result), .reg_write_i(rw), .reg_addr_i(ra),
    .output_valid_o(b_valid), .reg_write_o(b_rw), .reg_addr_o(b_ra), .reg_data_o(b_data),
    .misaligned_o(b_mis), .bus_error_o(b_berr), .wb_adr_o(b_adr), .wb_dat_o(b_dat),
    .wb_dat_i(wb_rdata), .wb_we_o(b_we), .wb_sel_o(b_sel), .wb_stb_o(b_stb),
    .wb_cyc_o(b_cyc), .wb_stall_i(stall), .wb_ack_i(ack)
  );

  typedef struct packed {
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_out(input logic e_rw, input logic [4:0] e_ra, input logic [31:0] e_data,
                            input logic e_chk, input logic e_mis, input logic e_berr);
    exp_t e;
    e.rw = e_rw; e.ra = e_ra; e.data = e_data; e.chk_data = e_chk; e.mis = e_mis; e.berr = e_berr;
    sb_q.push_back(e);
  endtask

  // Presents one instruction for a single cycle; returns one cycle after acceptance.
  task automatic issue(input logic to_b, input logic m, input logic we, input logic [2:0] fn,
                       input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] res,
                       input logic w, input logic [4:0] r);
    chk("ready_before_issue", 32'(to_b ? b_ready : a_ready), 32'd1);
    mem_en = m; mem_we = we; f3 = fn; addr = ad; wdata = wd; result = res; rw = w; ra = r;
    if (to_b) valid_b = 1'b1; else valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // Load acked in the same cycle the request is presented without stall.
  task automatic load_fast(input logic [2:0] fn, input logic [31:0] ad, input logic [31:0] rdata,
                           input logic [31:0] exp_data, input logic [4:0] r);
    expect_out(1'b1, r, exp_data, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b0, fn, ad, 32'd0, 32'd0, 1'b1, r);
    chk("fast_adr", a_adr, {ad[31:2], 2'b00});
    ack = 1'b1; wb_rdata = rdata;
    step();
    ack = 1'b0;
    chk("fast_valid", 32'(a_valid), 32'd1);
    step();
  endtask

  // Load with ack two cycles after the strobe cycle.
  task automatic load_slow(input logic [2:0] fn, input logic [31:0] exp_data, input logic [4:0] r);
    expect_out(1'b1, r, exp_data, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b0, fn, 32'h0000_1003, 32'd0, 32'd0, 1'b1, r);
    chk("lb_cyc", 32'(a_cyc), 32'd1);
    chk("lb_stb", 32'(a_stb), 32'd1);
    chk("lb_adr", a_adr, 32'h0000_1000);
    chk("lb_sel", 32'(a_sel), 32'h8);
    chk("lb_we", 32'(a_we), 32'd0);
    step();
    chk("lb_stb_dropped", 32'(a_stb), 32'd0);
    chk("lb_cyc_held", 32'(a_cyc), 32'd1);
    step();
    ack = 1'b1; wb_rdata = 32'h80FF_0000;
    step();
    ack = 1'b0;
    chk("lb_cyc_done", 32'(a_cyc), 32'd0);
    chk("lb_valid", 32'(a_valid), 32'd1);
    step();
  endtask

  always @(negedge clk) begin
    if (!rst && a_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output_valid", 32'(a_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_reg_write", 32'(a_rw), 32'(mon_e.rw));
        chk("out_reg_addr", 32'(a_ra), 32'(mon_e.ra));
        if (mon_e.chk_data) chk("out_reg_data", a_data, mon_e.data);
        chk("out_misaligned", 32'(a_mis), 32'(mon_e.mis));
        chk("out_bus_error", 32'(a_berr), 32'(mon_e.berr));
      end
    end
  end

  initial begin
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; mem_en = 1'b0; mem_we = 1'b0; f3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; result = 32'd0; rw = 1'b0; ra = 5'd0;
    wb_rdata = 32'd0; stall = 1'b0; ack = 1'b0;
    step(); step();
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_cyc", 32'(a_cyc), 32'd0);
    chk("rst_stb", 32'(a_stb), 32'd0);
    chk("rst_sel", 32'(a_sel), 32'd0);
    chk("rst_adr", a_adr, 32'd0);
    chk("rst_data", a_data, 32'd0);
    chk("rst_flags", 32'({a_rw, a_mis, a_berr, a_we}), 32'd0);
    rst = 1'b0;
    step();

    // Non-memory pass-through, latency 1
    expect_out(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'hDEAD_BEEF, 1'b1, 5'd5);
    chk("alu_valid", 32'(a_valid), 32'd1);
    chk("alu_no_cyc", 32'(a_cyc), 32'd0);
    step();
    chk("alu_valid_pulse", 32'(a_valid), 32'd0);

    load_slow(3'b000, 32'hFFFF_FF80, 5'd7);
    load_slow(3'b100, 32'h0000_0080, 5'd8);

    // SH with stall held three cycles
    stall = 1'b1;
    expect_out(1'b0, 5'd9, 32'd0, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 1'b1, 5'd9);
    chk("sh_sel", 32'(a_sel), 32'hC);
    chk("sh_dat", a_dat, 32'hABCD_ABCD);
    chk("sh_we", 32'(a_we), 32'd1);
    repeat (3) begin
      chk("sh_stb_stalled", 32'(a_stb), 32'd1);
      step();
    end
    stall = 1'b0;
    chk("sh_stb_last", 32'(a_stb), 32'd1);
    step();
    chk("sh_stb_dropped", 32'(a_stb), 32'd0);
    chk("sh_cyc_held", 32'(a_cyc), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("sh_valid", 32'(a_valid), 32'd1);
    step();

    // LW acked in the cycle stall falls
    stall = 1'b1;
    expect_out(1'b1, 5'd3, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'd0, 32'd0, 1'b1, 5'd3);
    chk("lw_adr", a_adr, 32'h0000_0004);
    chk("lw_sel", 32'(a_sel), 32'hF);
    step();
    stall = 1'b0; ack = 1'b1; wb_rdata = 32'h1234_5678;
    step();
    ack = 1'b0;
    chk("lw_valid_next", 32'(a_valid), 32'd1);
    chk("lw_cyc_done", 32'(a_cyc), 32'd0);
    step();
    chk("lw_valid_pulse", 32'(a_valid), 32'd0);

    // Misaligned LH and illegal load func3
    expect_out(1'b0, 5'd4, 32'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0001, 32'd0, 32'd0, 1'b1, 5'd4);
    chk("lh_mis_valid", 32'(a_valid), 32'd1);
    chk("lh_mis_no_bus", 32'({a_cyc, a_stb}), 32'd0);
    step();
    expect_out(1'b0, 5'd6, 32'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'd0, 32'd0, 1'b1, 5'd6);
    chk("f3_011_valid", 32'(a_valid), 32'd1);
    chk("f3_011_no_bus", 32'({a_cyc, a_stb}), 32'd0);
    step();

    // SB lane/replication, acked with the strobe
    expect_out(1'b0, 5'd10, 32'd0, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0011, 32'h1234_565A, 32'd0, 1'b1, 5'd10);
    chk("sb_sel", 32'(a_sel), 32'h2);
    chk("sb_dat", a_dat, 32'h5A5A_5A5A);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("sb_valid", 32'(a_valid), 32'd1);
    step();

    load_fast(3'b001, 32'h0000_0102, 32'h8001_1234, 32'hFFFF_8001, 5'd11);
    load_fast(3'b101, 32'h0000_0100, 32'hBEEF_F00D, 32'h0000_F00D, 5'd12);

    // Timeout on the ACK_TIMEOUT=4 instance
    issue(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'd0, 1'b1, 5'd2);
    repeat (4) begin
      chk("to_cyc_held", 32'(b_cyc), 32'd1);
      step();
    end
    chk("to_cyc_dropped", 32'(b_cyc), 32'd0);
    chk("to_stb_dropped", 32'(b_stb), 32'd0);
    chk("to_valid", 32'(b_valid), 32'd1);
    chk("to_bus_error", 32'(b_berr), 32'd1);
    chk("to_reg_write", 32'(b_rw), 32'd0);
    step();
    chk("to_valid_pulse", 32'(b_valid), 32'd0);
    chk("to_ready", 32'(b_ready), 32'd1);

    // Asynchronous reset while waiting for an ack
    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'd0, 32'd0, 1'b1, 5'd1);
    step();
    chk("rw_wait_cyc", 32'(a_cyc), 32'd1);
    chk("rw_wait_stb", 32'(a_stb), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_cyc", 32'(a_cyc), 32'd0);
    chk("rst_async_ready", 32'(a_ready), 32'd1);
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("rst_no_output", 32'(a_valid), 32'd0);
    end
    chk("rst_ready_after", 32'(a_ready), 32'd1);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/loadstore_unit.md
Name: loadstore_unit

Overview:
- Memory-access stage of the ECAP5-DPROC pipeline. Sits between execute and writeback.
- Consumes the FUNC3 load/store encodings (LB/LH/LW/LBU/LHU, SB/SH/SW) and acts as the Wishbone pipelined initiator on the data bus.
- Performs lane selection and sign/zero extension, and passes non-memory results through to writeback.

Parameters:
- ACK_TIMEOUT, 255, number of cycles allowed in REQUEST/WAIT_ACK before the access is aborted with bus_error_o; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- input_valid_i  in  1  execute stage presents an instruction
- input_ready_o  out  1  unit can accept an instruction
- mem_enable_i  in  1  instruction is a load or store
- mem_we_i  in  1  1 = store, 0 = load
- func3_i  in  3  FUNC3 field of the instruction
- addr_i  in  32  effective byte address
- wdata_i  in  32  store data (rs2)
- result_i  in  32  ALU result for non-memory instructions
- reg_write_i  in  1  instruction writes rd
- reg_addr_i  in  5  rd index
- output_valid_o  out  1  one-cycle pulse, writeback data valid
- reg_write_o  out  1  writeback enable
- reg_addr_o  out  5  rd index
- reg_data_o  out  32  writeback data
- misaligned_o  out  1  qualified by output_valid_o; access not issued
- bus_error_o  out  1  qualified by output_valid_o; timeout abort
- wb_adr_o  out  32  word address: addr_i[31:2], 2'b00
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_we_o  out  1  write enable
- wb_sel_o  out  4  byte lane select
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_stall_i  in  1  slave stall
- wb_ack_i  in  1  slave acknowledge

Behaviour:
- Reset: every output is 0 except input_ready_o = 1. FSM is in IDLE and the timeout counter is 0.
- FSM states: IDLE, REQUEST, WAIT_ACK, OUTPUT.
- input_ready_o = 1 only in IDLE. An instruction is accepted on input_valid_i & input_ready_o. All inputs are registered at acceptance.
- IDLE with mem_enable_i = 0: go to OUTPUT. Next cycle output_valid_o = 1 with reg_data_o = result_i (latency 1).
- IDLE, memory access, legal and aligned: go to REQUEST. Next cycle wb_cyc_o = wb_stb_o = 1 and the address, data, sel and we outputs are driven.
- Legality: load func3 in {000,001,010,100,101}; store func3 in {000,001,010}. Any other func3 is treated as misaligned.
- Alignment: H requires addr[0] = 0; W requires addr[1:0] = 0.
- Illegal or misaligned access: no bus cycle. Go to OUTPUT with misaligned_o = 1 and reg_write_o = 0.
- REQUEST: hold stb and all bus outputs while wb_stall_i = 1.
  - Stall low without ack: drop stb, keep cyc, go to WAIT_ACK.
  - Stall low with ack in the same cycle: drop stb and cyc, capture data, go to OUTPUT.
- WAIT_ACK: on wb_ack_i, drop cyc, capture wb_dat_i, go to OUTPUT. An ack seen outside REQUEST/WAIT_ACK is ignored.
- OUTPUT: output_valid_o = 1 for exactly one cycle, then return to IDLE. Writeback has no backpressure.
- Timeout: the counter increments each cycle in REQUEST/WAIT_ACK. When it reaches ACK_TIMEOUT, drop cyc and stb and go to OUTPUT with bus_error_o = 1 and reg_write_o = 0.
- Store lanes:
  - SB: wb_sel_o = 4'b0001 << addr[1:0]; data byte replicated to all 4 lanes.
  - SH: wb_sel_o = 4'b0011 << (2*addr[1]); data halfword replicated to both halves.
  - SW: wb_sel_o = 4'hF.
  - Stores force reg_write_o = 0.
- Load lanes: wb_sel_o is computed as for stores with we = 0.
  - LB/LBU: extract byte addr[1:0], sign-extend (LB) or zero-extend (LBU).
  - LH/LHU: extract halfword addr[1], sign-extend (LH) or zero-extend (LHU).
  - LW: whole word.
- Reset mid-access: asynchronous. cyc and stb drop immediately; the pending instruction is discarded with no output_valid_o.

Decomposition:
- Shared package: add FSM state constants LSU_IDLE/LSU_REQUEST/LSU_WAIT_ACK/LSU_OUTPUT (2-bit), alongside the existing FUNC3 load/store constants.
- One natural combinational sub-module, lsu_lane_align: sel/wdata generation and load extraction/extension. All sequencing stays in loadstore_unit.

Test Plan:
- Non-memory op: result_i = 32'hDEADBEEF, reg_addr_i = 5 -> one cycle later output_valid_o = 1, reg_data_o = DEADBEEF, reg_write_o = 1; no cyc.
- LB at addr 32'h1003, slave returns 32'h80FF_0000 with ack two cycles after stb, no stall -> wb_adr_o = 1000, wb_sel_o = 1000b, reg_data_o = FFFFFF80. Same access with LBU -> 00000080.
- SH at addr 32'h2002, wdata 32'h0000ABCD, stall held 3 cycles -> stb held 3+1 cycles, wb_sel_o = 1100b, wb_dat_o = ABCDABCD, we = 1, reg_write_o = 0 at output.
- LW at addr 32'h0004 with ack in the same cycle stall falls -> output_valid_o exactly 1 cycle after that edge, no WAIT_ACK cycle, reg_data_o = wb_dat_i.
- LH at addr 32'h0001, and load func3 = 011 -> no stb/cyc ever, misaligned_o = 1, reg_write_o = 0.
- ACK_TIMEOUT = 4, slave never acks -> cyc drops after 4 cycles, bus_error_o = 1. Separately, assert rst_i while in WAIT_ACK -> cyc = 0 immediately, no output_valid_o, input_ready_o = 1.
